seven_seg_scan_driver: RTL
==========================

// Module: seven_seg_scan_driver
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
//  Snapshots a packed BCD word once per scan frame and cycles the digit enables at a programmable rate.
//  Decodes each digit to segments {a,b,c,d,e,f,g}, with leading-zero blanking and per-digit decimal points.
//  Sits between counter/converter datapaths and the board display pins.
// PARAMETERS
//  NUM_DIGITS  4     number of digits scanned (1..8)
//  CLK_DIV     1000  clk cycles each digit stays lit (>=2)
//  ACTIVE_LOW  0     1: invert seg, dp, an at the output registers
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              synchronous active-high reset
//  enable     in   1              1: scan runs; 0: display dark, counters hold
//  bcd_in     in   4*NUM_DIGITS   packed digits; [3:0] = digit 0 (least significant)
//  dp_in      in   NUM_DIGITS     decimal point per digit; bit k = digit k
//  blank_lz   in   1              1: blank leading zeros
//  seg        out  7              segments, seg[6]=a ... seg[0]=g (active-high when ACTIVE_LOW=0)
//  dp         out  1              decimal point of the lit digit
//  an         out  NUM_DIGITS     one-hot digit enable; bit k lights digit k
//  frame_start out 1              one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  - Reset, all outputs registered: seg=0, dp=0, an=0, frame_start=0 (all inverted if ACTIVE_LOW); prescaler=0, idx=0, snap=0.
//  - Prescaler counts 0..CLK_DIV-1 while enable=1; at CLK_DIV-1 it wraps to 0 and idx advances, NUM_DIGITS-1 -> 0.
//  - Snapshot: when enable=1 and prescaler==0 and idx==0, snap<=bcd_in, snap_dp<=dp_in, snap_lz<=blank_lz,
//    and frame_start pulses 1 on the next cycle. Input changes mid-frame never tear the displayed value.
//  - Output stage: seg/dp/an are registered from (idx, snap), so they lag idx by 1 cycle.
//    Digit k is lit for exactly CLK_DIV consecutive cycles per frame; frame period = NUM_DIGITS*CLK_DIV.
//  - Decode 0-9: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111
//    7=1110000 8=1111111 9=1111011. Codes 10-15: seg=0000000 (blank), unless HEX_DIGITS_EN.
//  - Leading-zero blanking (snap_lz=1): digit k>0 is blanked (seg=0, dp from snap_dp still driven)
//    when snap digits k..NUM_DIGITS-1 all equal 0. Digit 0 is never blanked; value 0 shows a single "0".
//  - an stays one-hot while enabled even if the digit is blanked (constant refresh duty).
//  - enable=0: next cycle an=0, seg=0, dp=0, frame_start=0; prescaler, idx, snap hold.
//    On re-enable the scan resumes at the held prescaler/idx; no new snapshot until the next idx==0, prescaler==0.
//  - rst mid-frame: next cycle returns to the reset state; with enable=1, the first snapshot is taken on the cycle
//    after rst deasserts.
// CONFIGURATION
//  HEX_DIGITS_EN defined: codes 10-15 decode to A=1110111 b=0011111 C=1001110 d=0111101
//    E=1001111 F=1000111; leading-zero blanking still treats only 0 as zero.
//  HEX_DIGITS_EN undefined: codes 10-15 display blank; all other behaviour identical.
// TESTING (NUM_DIGITS=4, CLK_DIV=4, ACTIVE_LOW=0 unless stated)
//  1. rst, then enable=1, bcd_in=16'h1234 -> an sequence 0001,0010,0100,1000, each held 4 cycles;
//     seg 0110011,1111001,1101101,0110000; frame_start once per 16 cycles.
//  2. Sweep digit 0 through 0..9 across frames -> seg matches decode table; 4'hA -> 0000000 (no HEX_DIGITS_EN)
//     or 1110111 (HEX_DIGITS_EN).
//  3. blank_lz=1, bcd_in=16'h0050 -> digits 3,2 seg=0; digit 1=1011011; digit 0=1111110.
//     bcd_in=0 -> only digit 0 shows 1111110.
//  4. Change bcd_in 16'h1111->16'h2222 while digit 2 is lit -> rest of frame shows 1; next frame shows 2.
//  5. enable=0 for 10 cycles mid-digit -> an=0, seg=0; re-enable resumes on the same digit with the remaining count.
//  6. ACTIVE_LOW=1, dp_in=4'b0100, bcd_in=16'h8888 -> seg=0000000 (all on);
//     dp=0 only while an=1011; rst mid-frame -> all outputs 1 next cycle.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
//   Time-multiplexed driver for an N-digit 7-segment display. A packed BCD word
//   (with per-digit decimal points and the leading-zero-blank flag) is
//   snapshotted once per scan frame. The digit enables then cycle at a rate of
//   CLK_DIV clocks per digit. Each digit is decoded to segments {a..g}.
//
//   Optional feature macro: HEX_DIGITS_EN
//     defined   : codes 10-15 decode to A b C d E F
//     undefined : codes 10-15 display blank
//
// Parameters
//   NUM_DIGITS  number of digits scanned (1..8)
//   CLK_DIV     clk cycles each digit stays lit (>= 2)
//   ACTIVE_LOW  1: seg, dp, an and frame_start are inverted at the output flops
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       1: scan runs; 0: display dark, counters and snapshot hold
//   bcd_in       packed digits, [3:0] = digit 0 (least significant)
//   dp_in        decimal point per digit, bit k = digit k
//   blank_lz     1: blank leading zeros
//   seg          segments, seg[6]=a ... seg[0]=g
//   dp           decimal point of the lit digit
//   an           one-hot digit enable, bit k lights digit k
//   frame_start  one-cycle pulse when a new snapshot is taken
// -----------------------------------------------------------------------------
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 1000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic             INV      = 1'(ACTIVE_LOW != 0);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_lz_q, snap_lz_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic                    take_snap;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    upper_nonzero;
  logic                    blank_digit;
  logic [6:0]              seg_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  function automatic logic [6:0] decode_digit(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
`ifdef HEX_DIGITS_EN
      4'd10:   s = 7'b1110111;
      4'd11:   s = 7'b0011111;
      4'd12:   s = 7'b1001110;
      4'd13:   s = 7'b0111101;
      4'd14:   s = 7'b1001111;
      4'd15:   s = 7'b1000111;
`endif
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    snap_lz_d = snap_lz_q;

    take_snap = enable && (presc_q == '0) && (idx_q == '0);

    if (take_snap) begin
      snap_d    = bcd_in;
      snap_dp_d = dp_in;
      snap_lz_d = blank_lz;
    end

    if (enable) begin
      if (presc_q == PRE_LAST) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
      end else begin
        presc_d = presc_q + PRE_ONE;
      end
    end

    // The output stage reads the snapshot as it will be after this edge, so the
    // first digit of a new frame already shows the freshly captured word.
    cur_digit     = 4'd0;
    cur_dp        = 1'b0;
    upper_nonzero = 1'b0;
    an_raw        = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_digit = snap_d[4*k +: 4];
        cur_dp    = snap_dp_d[k];
        an_raw[k] = enable;
      end
      if ((IDX_W'(k) >= idx_q) && (snap_d[4*k +: 4] != 4'd0)) begin
        upper_nonzero = 1'b1;
      end
    end

    // Digit 0 is never blanked, so a value of zero still shows one "0".
    blank_digit = snap_lz_d && (idx_q != '0) && !upper_nonzero;

    seg_raw = (enable && !blank_digit) ? decode_digit(cur_digit) : 7'b0000000;

    seg_d         = seg_raw ^ {7{INV}};
    dp_d          = (enable && cur_dp) ^ INV;
    an_d          = an_raw ^ {NUM_DIGITS{INV}};
    frame_start_d = take_snap ^ INV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q       <= '0;
      idx_q         <= '0;
      snap_q        <= '0;
      snap_dp_q     <= '0;
      snap_lz_q     <= 1'b0;
      seg_q         <= {7{INV}};
      dp_q          <= INV;
      an_q          <= {NUM_DIGITS{INV}};
      frame_start_q <= INV;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      snap_dp_q     <= snap_dp_d;
      snap_lz_q     <= snap_lz_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule
